ahbl_apb_bridge_nslot: RTL

AHB-Lite slave to APB3 master bridge with a parametrised number of APB slave selects, PREADY wait-state support, PSLVERR-to-HRESP error mapping, unmapped-slot detection and an optional access timeout. It is the next-generation bridge for the bus-functional-model test harnesses and for peripheral subsystems. It sits behind one AHB-Lite HSEL line and fans out to up to 16 APB peripherals.

---
 rtl/ahbl_apb_bridge_nslot.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ahbl_apb_bridge_nslot.sv
// AHB-Lite slave to APB3 master bridge: decodes a 4-bit slot field onto NUM_SLAVES PSEL lines,
// stretches HREADYOUT over PREADY wait states and maps PSLVERR/unmapped/timeout to a two-cycle ERROR.
module ahbl_apb_bridge_nslot #(
  parameter int NUM_SLAVES = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLOT_LSB   = 8,
  parameter int TIMEOUT    = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_haddr;

  logic                  w_accept;
  logic                  w_unmapped;
  logic                  w_timeout;
  logic [3:0]            w_slot;
  logic [3:0]            w_wslot;

  function automatic logic [NUM_SLAVES-1:0] f_onehot(input logic [3:0] s);
    logic [NUM_SLAVES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SLAVES; i++) v[i] = (s == 4'(i));
    return v;
  endfunction

  assign w_accept   = HSEL & HTRANS[1] & HREADYIN;
  assign w_slot     = HADDR[SLOT_LSB+3:SLOT_LSB];
  assign w_wslot    = r_haddr[SLOT_LSB+3:SLOT_LSB];
  assign w_unmapped = ({1'b0, w_slot} >= 5'(NUM_SLAVES));

  generate
    if (TIMEOUT > 0) begin : g_to
      assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    end else begin : g_no_to
      assign w_timeout = 1'b0;
    end
  endgenerate

  // All bus outputs are registered alongside the state so they reflect the state being entered.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_haddr   <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      PADDR     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
    end else begin
      case (r_state)
        S_WDATA: begin
          PWDATA  <= HWDATA;
          PADDR   <= r_haddr;
          PWRITE  <= 1'b1;
          PSEL    <= f_onehot(w_wslot);
          r_state <= S_SETUP;
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            r_cnt   <= '0;
            if (PSLVERR) begin
              HRESP   <= 1'b1;
              r_state <= S_ERR1;
            end else begin
              HREADYOUT <= 1'b1;
              if (!PWRITE) HRDATA <= PRDATA;
              r_state <= S_DONE;
            end
          end else if (w_timeout) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            r_cnt   <= '0;
            HRESP   <= 1'b1;
            r_state <= S_ERR1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ERR1: begin
          HREADYOUT <= 1'b1;
          r_state   <= S_ERR2;
        end
        default: begin
          // IDLE, DONE and ERR2 all sit in a ready cycle and may take a new address phase.
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          r_state   <= S_IDLE;
          if (w_accept) begin
            r_haddr   <= HADDR;
            HREADYOUT <= 1'b0;
            if (w_unmapped) begin
              HRESP   <= 1'b1;
              r_state <= S_ERR1;
            end else if (HWRITE) begin
              r_state <= S_WDATA;
            end else begin
              PADDR   <= HADDR;
              PWRITE  <= 1'b0;
              PSEL    <= f_onehot(w_slot);
              r_state <= S_SETUP;
            end
          end
        end
      endcase
    end
  end
endmodule
